// File: rtl/div.sv
// Iterative 32-bit restoring divider (DIV/DIVU) with annul and divide-by-zero handling.
// result_o packs {remainder, quotient}; both outputs are registered.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] divisor_q;
    logic        quot_neg_q;
    logic        rem_neg_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes, and one restoring step on a 33-bit partial remainder.
    always_comb begin
        mag_a    = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag_b    = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        shifted  = {rem_q, quot_q[31]};
        diff     = shifted - {1'b0, divisor_q};
        quot_fix = quot_neg_q ? (~quot_q + 32'd1) : quot_q;
        rem_fix  = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FREE;
            cnt        <= 6'd0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            divisor_q  <= 32'd0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state      <= ON;
                            cnt        <= 6'd0;
                            rem_q      <= 32'd0;
                            quot_q     <= mag_a;
                            divisor_q  <= mag_b;
                            quot_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            rem_neg_q  <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                BYZERO: begin
                    result_o <= 64'd0;
                    if (annul_i) begin
                        state   <= FREE;
                        ready_o <= 1'b0;
                    end else begin
                        state   <= END;
                        ready_o <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state    <= FREE;
                        cnt      <= 6'd0;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else if (cnt < 6'd32) begin
                        // The dividend shifts out of quot_q as quotient bits shift in.
                        if (!diff[32]) begin
                            rem_q  <= diff[31:0];
                            quot_q <= {quot_q[30:0], 1'b1};
                        end else begin
                            rem_q  <= shifted[31:0];
                            quot_q <= {quot_q[30:0], 1'b0};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    state    <= FREE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset. The ports are `clk` and `rst`; `rst` low forces the reset state immediately, regardless of the clock.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 signed_div_i  input  1  1 = signed (DIV) operation; 0 = unsigned (DIVU).
REQ-005 opdata1_i  input  32  dividend.
REQ-006 opdata2_i  input  32  divisor.
REQ-007 start_i  input  1  division request from the execute stage; held high until the result is consumed.
REQ-008 annul_i  input  1  cancel request (pipeline flush); overrides start_i.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}; registered.
REQ-010 ready_o  output  1  result_o is valid; registered.

Function
REQ-011 States SHALL be FREE, BYZERO, ON and END, encoded in a 2-bit state register, with a 6-bit step counter cnt.
REQ-012 FREE, on an edge with start_i=1 and annul_i=0:
- opdata2_i==0: go to BYZERO.
- otherwise: go to ON with cnt=0.
- Operands are latched as magnitudes: two's-complement negation when signed_div_i=1 and the operand MSB is 1, raw value otherwise.
- The quotient sign and the dividend sign are latched in the same edge.
REQ-013 FREE with start_i=0, or with annul_i=1, SHALL remain in FREE with ready_o=0 and result_o=0.
REQ-014 ON, on an edge with cnt<32, SHALL perform one restoring shift-subtract step and increment cnt:
- The partial remainder is 33 bits wide.
- Quotient bit = 1 when the subtraction does not borrow.
REQ-015 ON, on the edge with cnt==32, SHALL apply sign correction, register result_o, set ready_o=1 and go to END.
- Quotient is negated when signed_div_i=1 and the operand signs differed.
- Remainder takes the sign of the dividend.
REQ-016 Latency: ready_o SHALL first be observed high after the 34th rising edge, counting the accepting edge as edge 1.
REQ-017 BYZERO SHALL go to END on the next edge with result_o=0 and ready_o=1, i.e. ready_o is high after edge 2.
REQ-018 annul_i=1 in ON or BYZERO SHALL return the block to FREE on that edge, with ready_o=0 and result_o=0; no partial result is ever presented.
REQ-019 END SHALL hold result_o and ready_o stable while start_i=1.
REQ-020 END, on an edge with start_i=0, SHALL go to FREE with ready_o=0 and result_o=0.
REQ-021 Changes on opdata1_i, opdata2_i or signed_div_i after acceptance SHALL NOT affect the result.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0, with no trap or flag.
REQ-023 Signed division SHALL truncate toward zero.

Reset
REQ-024 While rst=0, the block SHALL force state=FREE, cnt=0, all datapath registers=0, result_o=0 and ready_o=0, asynchronously.
REQ-025 Deassertion of reset during an operation SHALL leave the block in FREE. Any in-flight division is discarded and requires a fresh start_i.

Verification
REQ-026 Unsigned case: 100/7, signed_div_i=0, start_i held.
- Required: ready_o rises after edge 34.
- Required: result_o = {32'd2, 32'd14}.
REQ-027 Signed case: -7/2 (0xFFFFFFF9 / 0x00000002), signed_div_i=1.
- Required: result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-028 Divide by zero: 5/0.
- Required: ready_o high after edge 2, result_o = 0.
- Required: start_i dropped -> ready_o=0 on the next edge.
REQ-029 Annul: start 100/7, assert annul_i for one cycle at cnt=10.
- Required: the block returns to FREE and ready_o never rises.
- Required: an immediate restart of 9/3 yields {0, 3} after 34 edges.
REQ-030 Boundary and reset cases:
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Pulse rst=0 mid-ON at cnt=20 -> ready_o=0 and result_o=0 immediately, without waiting for a clock edge.
